// File: rtl/mem_arbiter.sv
// Two-port line arbiter: instruction and data cache share one backing memory.
// One transaction is in flight at a time. Conflicts alternate on a one-bit
// last-grant register. Grants are combinational while idle.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_gnt,
  output logic                    ic_rvalid,
  output logic [LINE_BYTES*8-1:0] ic_rdata,
  input  logic                    dc_req,
  input  logic                    dc_we,
  input  logic [ADDR_WIDTH-1:0]   dc_addr,
  input  logic [LINE_BYTES*8-1:0] dc_wdata,
  output logic                    dc_gnt,
  output logic                    dc_rvalid,
  output logic [LINE_BYTES*8-1:0] dc_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_rdata
);

  localparam int LW = LINE_BYTES * 8;
  // Clears the byte-within-line offset bits.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  ic_rvalid_q, ic_rvalid_d;
  logic                  dc_rvalid_q, dc_rvalid_d;
  logic [LW-1:0]         ic_rdata_q, ic_rdata_d;
  logic [LW-1:0]         dc_rdata_q, dc_rdata_d;
  logic                  sel_ic, sel_dc;

  // Idle-only requester selection; a conflict goes to whoever was not granted last.
  always_comb begin
    sel_ic = 1'b0;
    sel_dc = 1'b0;
    if (state_q == IDLE) begin
      if (ic_req && dc_req) begin
        if (last_grant_q == OWN_DC) sel_ic = 1'b1;
        else                        sel_dc = 1'b1;
      end else if (ic_req) begin
        sel_ic = 1'b1;
      end else if (dc_req) begin
        sel_dc = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held, even if requests are present.
  assign ic_gnt = sel_ic & ~rst;
  assign dc_gnt = sel_dc & ~rst;

  // Next-state: launch on grant, retire on ack; rvalid defaults to a single pulse.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ic_rvalid_d  = 1'b0;
    dc_rvalid_d  = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    case (state_q)
      IDLE: begin
        if (sel_ic || sel_dc) begin
          state_d      = BUSY;
          owner_d      = sel_dc ? OWN_DC : OWN_IC;
          last_grant_d = sel_dc ? OWN_DC : OWN_IC;
          mem_req_d    = 1'b1;
          mem_we_d     = sel_dc & dc_we;
          mem_addr_d   = (sel_dc ? dc_addr : ic_addr) & LINE_MASK;
          mem_wdata_d  = sel_dc ? dc_wdata : '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_DC) begin
            dc_rvalid_d = 1'b1;
            dc_rdata_d  = mem_we_q ? '0 : mem_rdata;
          end else begin
            ic_rvalid_d = 1'b1;
            ic_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_DC;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ic_rvalid_q  <= 1'b0;
      dc_rvalid_q  <= 1'b0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_rvalid_q  <= ic_rvalid_d;
      dc_rvalid_q  <= dc_rvalid_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_rvalid = ic_rvalid_q;
  assign dc_rvalid = dc_rvalid_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for
// alternation and mid-transaction reset, then random traffic against a
// transaction-queue reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LB = 16;
  localparam int LW = LB * 8;
  localparam int OW = 4 + AW + LW + 2 + 2 * LW;

  localparam logic [LW-1:0] Z  = '0;
  localparam logic [LW-1:0] AA = {16{8'hAA}};
  localparam logic [LW-1:0] BB = {16{8'hBB}};
  localparam logic [LW-1:0] CC = {16{8'hCC}};
  localparam logic [LW-1:0] DD = {16{8'hDD}};
  localparam logic [LW-1:0] EE = {16{8'hEE}};
  localparam logic [LW-1:0] W  = 128'h11223344556677889900AABBCCDDEEFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, dc_req, dc_we, mem_ack;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_gnt, ic_rvalid, dc_gnt, dc_rvalid, mem_req, mem_we;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [OW-1:0] act_bus;

  int nvec = 0;
  int nmis = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign act_bus = {ic_gnt, dc_gnt, mem_req, mem_we, mem_addr, mem_wdata,
                    ic_rvalid, dc_rvalid, ic_rdata, dc_rdata};

  task automatic cmp(input string nm, input logic [OW-1:0] a, input logic [OW-1:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic cmp1(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  typedef struct {
    bit            rst, icr;
    logic [AW-1:0] ica;
    bit            dcr, we;
    logic [AW-1:0] dca;
    logic [LW-1:0] wd;
    bit            ack;
    logic [LW-1:0] mrd;
    bit            g_ic, g_dc, m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wd;
    bit            rv_ic, rv_dc;
    logic [LW-1:0] rd_ic, rd_dc;
  } vec_t;

  typedef struct {
    bit            dc;
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
  } txn_t;

  vec_t tbl[19];

  initial begin
    #500000;
    $display("FAIL timeout bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t          outq[$];
    txn_t          t;
    bit            last_dc, m_req_e, m_we_e, rv_ic_e, rv_dc_e, g_ic, g_dc, ic_won, dc_won;
    logic [AW-1:0] m_addr_e;
    logic [LW-1:0] m_wd_e, rd_ic_e, rd_dc_e, cap;
    int            ngr, lat, cnt;
    bit            outst, prev_req;

    //             rst icr ica          dcr we dca           wd ack mrd  gic gdc mrq mwe maddr          mwd rvi rvd rdi rdd
    tbl[0]  = '{0, 1, 32'h0000_1234, 0, 0, 32'h0,         Z, 0, Z,  1, 0, 0, 0, 32'h0,         Z, 0, 0, Z,  Z};
    tbl[1]  = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 1, 0, 32'h0000_1230, Z, 0, 0, Z,  Z};
    tbl[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 1, 0, 32'h0000_1230, Z, 0, 0, Z,  Z};
    tbl[3]  = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 1, AA, 0, 0, 1, 0, 32'h0000_1230, Z, 0, 0, Z,  Z};
    tbl[4]  = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 0, 0, 32'h0000_1230, Z, 1, 0, AA, Z};
    tbl[5]  = '{1, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 0, 0, 32'h0,         Z, 0, 0, Z,  Z};
    tbl[6]  = '{0, 1, 32'h100,       1, 0, 32'h200,       Z, 0, Z,  1, 0, 0, 0, 32'h0,         Z, 0, 0, Z,  Z};
    tbl[7]  = '{0, 0, 32'h0,         1, 0, 32'h200,       Z, 1, BB, 0, 0, 1, 0, 32'h100,       Z, 0, 0, Z,  Z};
    tbl[8]  = '{0, 0, 32'h0,         1, 0, 32'h200,       Z, 0, Z,  0, 1, 0, 0, 32'h100,       Z, 1, 0, BB, Z};
    tbl[9]  = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 1, CC, 0, 0, 1, 0, 32'h200,       Z, 0, 0, BB, Z};
    tbl[10] = '{0, 1, 32'h300,       1, 0, 32'h400,       Z, 0, Z,  1, 0, 0, 0, 32'h200,       Z, 0, 1, BB, CC};
    tbl[11] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 1, DD, 0, 0, 1, 0, 32'h300,       Z, 0, 0, BB, CC};
    tbl[12] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 0, 0, 32'h300,       Z, 1, 0, DD, CC};
    tbl[13] = '{0, 0, 32'h0,         1, 1, 32'h8000_004F, W, 0, Z,  0, 1, 0, 0, 32'h300,       Z, 0, 0, DD, CC};
    tbl[14] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 1, 1, 32'h8000_0040, W, 0, 0, DD, CC};
    tbl[15] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 1, EE, 0, 0, 1, 1, 32'h8000_0040, W, 0, 0, DD, CC};
    tbl[16] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 0, 0, 32'h8000_0040, W, 0, 1, DD, Z};
    tbl[17] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 1, EE, 0, 0, 0, 0, 32'h8000_0040, W, 0, 0, DD, Z};
    tbl[18] = '{0, 0, 32'h0,         0, 0, 32'h0,         Z, 0, Z,  0, 0, 0, 0, 32'h8000_0040, W, 0, 0, DD, Z};

    // Reset with both requests asserted: every output must read zero.
    rst = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; mem_ack = 1'b0;
    ic_addr = 32'h1234; dc_addr = 32'h5678; dc_wdata = Z; mem_rdata = Z;
    @(negedge clk);
    cmp("reset_state", act_bus, '0);

    // Directed table: single fetch, first conflict, data write, idle ack.
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; ic_req = tbl[i].icr; ic_addr = tbl[i].ica;
      dc_req = tbl[i].dcr; dc_we = tbl[i].we; dc_addr = tbl[i].dca; dc_wdata = tbl[i].wd;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].mrd;
      @(negedge clk);
      cmp($sformatf("row%0d", i), act_bus,
          {tbl[i].g_ic, tbl[i].g_dc, tbl[i].m_req, tbl[i].m_we, tbl[i].m_addr, tbl[i].m_wd,
           tbl[i].rv_ic, tbl[i].rv_dc, tbl[i].rd_ic, tbl[i].rd_dc});
    end

    // Both caches hold requests: grants must alternate ic, dc, ic, dc, ...
    @(posedge clk); #1;
    mem_ack = 1'b0; ic_addr = 32'h1000; dc_addr = 32'h2000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    ngr = 0; outst = 1'b0; prev_req = mem_req;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      @(negedge clk);
      cmp1("both_gnt", 32'(ic_gnt & dc_gnt), 32'd0);
      if (ic_gnt || dc_gnt) begin
        cmp1($sformatf("alt%0d", ngr), 32'(dc_gnt), 32'(ngr % 2));
        ngr++;
      end
      @(posedge clk); #1;
      if (mem_req && !prev_req) begin
        cmp1("req_rise_outstanding", 32'(outst), 32'd0);
        outst = 1'b1;
      end
      prev_req = mem_req;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_ack = mem_req;
      if (mem_ack) outst = 1'b0;
    end
    cmp1("six_grants", 32'(ngr), 32'd6);
    @(posedge clk); #1;
    ic_req = 1'b0; dc_req = 1'b0; mem_ack = mem_req;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // Reset in the middle of a transaction, then a late ack.
    ic_req = 1'b1; ic_addr = 32'h40;
    @(negedge clk);
    cmp1("mid_gnt", 32'(ic_gnt), 32'd1);
    @(posedge clk); #1;
    ic_req = 1'b0;
    @(negedge clk);
    cmp1("mid_busy", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    cmp("mid_in_reset", act_bus, '0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = EE;
    @(negedge clk);
    cmp("late_ack", act_bus, '0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    cmp("no_rvalid_after", act_bus, '0);
    @(posedge clk); #1;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h123;
    @(negedge clk);
    cmp1("post_gnt", 32'(dc_gnt), 32'd1);
    @(posedge clk); #1;
    dc_req = 1'b0; mem_ack = 1'b1; mem_rdata = CC;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    cmp("post_done", OW'({dc_rvalid, dc_rdata}), OW'({1'b1, CC}));

    // Random traffic against the transaction-queue model.
    @(posedge clk); #1;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_dc = 1'b1; m_req_e = 0; m_we_e = 0; m_addr_e = '0; m_wd_e = '0;
    rv_ic_e = 0; rv_dc_e = 0; rd_ic_e = '0; rd_dc_e = '0;
    ic_won = 0; dc_won = 0; lat = 1; cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (ic_won) ic_req = 1'b0;
      else if (ic_req && $urandom_range(19) == 0) ic_req = 1'b0;
      if (!ic_req && $urandom_range(2) == 0) begin
        ic_req = 1'b1; ic_addr = $urandom;
      end
      if (dc_won) dc_req = 1'b0;
      else if (dc_req && $urandom_range(19) == 0) dc_req = 1'b0;
      if (!dc_req && $urandom_range(2) == 0) begin
        dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(1));
        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (outq.size() > 0) begin
        cnt++;
        mem_ack = (cnt >= lat);
      end else begin
        mem_ack = ($urandom_range(7) == 0);
      end
      @(negedge clk);
      g_ic = 0; g_dc = 0;
      if (outq.size() == 0) begin
        if (ic_req && dc_req) begin
          if (last_dc) g_ic = 1; else g_dc = 1;
        end else begin
          g_ic = ic_req;
          g_dc = dc_req;
        end
      end
      cmp($sformatf("rand%0d", c), act_bus,
          {g_ic, g_dc, m_req_e, m_we_e, m_addr_e, m_wd_e, rv_ic_e, rv_dc_e, rd_ic_e, rd_dc_e});
      rv_ic_e = 0; rv_dc_e = 0;
      if (outq.size() > 0 && mem_ack) begin
        t = outq.pop_front();
        m_req_e = 0; m_we_e = 0;
        cap = mem_rdata;
        if (t.dc) begin
          rv_dc_e = 1;
          rd_dc_e = t.we ? Z : cap;
        end else begin
          rv_ic_e = 1;
          rd_ic_e = cap;
        end
      end else if (g_ic || g_dc) begin
        t.dc   = g_dc;
        t.we   = g_dc && dc_we;
        t.addr = g_dc ? dc_addr : ic_addr;
        t.wd   = g_dc ? dc_wdata : Z;
        outq.push_back(t);
        m_req_e  = 1;
        m_we_e   = t.we;
        m_addr_e = t.addr & ~AW'(LB - 1);
        m_wd_e   = t.wd;
        last_dc  = g_dc;
        lat = $urandom_range(4, 1);
        cnt = 0;
      end
      ic_won = g_ic;
      dc_won = g_dc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
